div_share_arbiter: RTL and testbench

- Shares one external in-order divider between two AXI-Stream requesters in the Schmidl-Cox metric path, e.g. the timing metric and the CFO normalisation.
- Arbitrates round-robin at packet (tlast) boundaries and forces zero divisors to 1.
- Records which requester issued each operation in a tag FIFO, and routes divider results back to that requester in order.
- Caps in-flight operations at DEPTH.

---
 rtl/div_share_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_div_share_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// Shares one in-order divider between two AXI-Stream requesters. Packets are
// granted round-robin, and a tag FIFO routes each quotient back to the requester that issued it.
module div_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,

   input  logic [4*WIDTH-1:0]   s_tdata,
   input  logic [1:0]           s_tlast,
   input  logic [1:0]           s_tvalid,
   output logic [1:0]           s_tready,

   output logic [2*WIDTH-1:0]   m_div_tdata,
   output logic                 m_div_tlast,
   output logic                 m_div_tvalid,
   input  logic                 m_div_tready,

   input  logic [WIDTH-1:0]     s_div_tdata,
   input  logic                 s_div_tlast,
   input  logic                 s_div_tvalid,
   output logic                 s_div_tready,

   output logic [2*WIDTH-1:0]   m_tdata,
   output logic [1:0]           m_tlast,
   output logic [1:0]           m_tvalid,
   input  logic [1:0]           m_tready,

   output logic                 protocol_err
);

   localparam int             PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      GNT0,
      GNT1
   } state_t;

   state_t             state;
   logic               last_gnt;
   logic [PTR_W:0]     count;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               tag_mem [DEPTH];

   logic               issue_ok;
   logic               sel;
   logic               accept;
   logic               pop;
   logic               empty;
   logic               head;
   logic [2*WIDTH-1:0] sel_beat;
   logic [WIDTH-1:0]   sel_dividend;
   logic [WIDTH-1:0]   sel_divisor;
   logic [WIDTH-1:0]   safe_divisor;
   logic               sel_last;

   // Issue is gated on a free output slot and on the registered in-flight count.
   // A pop in the same cycle does not reopen a full window.
   assign issue_ok    = (!m_div_tvalid || m_div_tready) && (count < DEPTH_CNT);
   assign s_tready[0] = (state == GNT0) && issue_ok;
   assign s_tready[1] = (state == GNT1) && issue_ok;

   assign sel          = (state == GNT1);
   assign accept       = |(s_tvalid & s_tready);
   assign sel_beat     = sel ? s_tdata[4*WIDTH-1:2*WIDTH] : s_tdata[2*WIDTH-1:0];
   assign sel_last     = sel ? s_tlast[1] : s_tlast[0];
   assign sel_dividend = sel_beat[2*WIDTH-1:WIDTH];
   assign sel_divisor  = sel_beat[WIDTH-1:0];
   assign safe_divisor = (sel_divisor == '0) ? WIDTH'(1) : sel_divisor;

   // Packet-level round-robin grant.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      if (reset) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else if (clear) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               case (s_tvalid)
                  2'b01:   state <= GNT0;
                  2'b10:   state <= GNT1;
                  2'b11:   state <= last_gnt ? GNT0 : GNT1;
                  default: state <= IDLE;
               endcase
            end
            GNT0: begin
               if (accept && sel_last) begin
                  last_gnt <= 1'b0;
                  state    <= IDLE;
               end
            end
            GNT1: begin
               if (accept && sel_last) begin
                  last_gnt <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // One-entry output register towards the divider.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_div_tvalid <= 1'b0;
         m_div_tlast  <= 1'b0;
         m_div_tdata  <= '0;
      end else if (clear) begin
         m_div_tvalid <= 1'b0;
         m_div_tlast  <= 1'b0;
         m_div_tdata  <= '0;
      end else if (accept) begin
         m_div_tvalid <= 1'b1;
         m_div_tlast  <= sel_last;
         m_div_tdata  <= {sel_dividend, safe_divisor};
      end else if (m_div_tready) begin
         m_div_tvalid <= 1'b0;
      end
   end

   assign pop   = s_div_tvalid && s_div_tready;
   assign empty = (count == '0);
   assign head  = tag_mem[rd_ptr];

   // Tag FIFO pointers and in-flight count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         protocol_err <= 1'b0;
      end else if (clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (s_div_tvalid && empty) protocol_err <= 1'b1;
      end
   end

   // NOTE: the tag storage has no reset; entries are only read behind a valid
   // write pointer, so clearing the pointers and count is sufficient.
   always_ff @(posedge clk) begin
      if (accept) tag_mem[wr_ptr] <= sel;
   end

   // Results are steered to the head tag with no added latency.
   always_comb begin
      // NOTE: default every output first so no path through the block leaves
      // a value held, which would infer a latch.
      m_tvalid = '0;
      m_tlast  = '0;
      if (!empty) begin
         m_tvalid[head] = s_div_tvalid;
         m_tlast[head]  = s_div_tlast;
      end
   end

   assign s_div_tready = !empty && m_tready[head];
   assign m_tdata      = {2{s_div_tdata}};

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a 4-cycle in-order divider model.
// It covers a single packet, contention, the zero divisor, the in-flight cap, backpressure and reset.
module tb_div_share_arbiter;

   localparam int W = 32;
   localparam int D = 4;

   typedef struct { int k; int cyc; } acc_t;
   typedef struct { logic [2*W-1:0] data; logic last; int cyc; } mdiv_t;
   typedef struct { int k; logic [W-1:0] data; logic last; } res_t;
   typedef struct { logic [W-1:0] q; logic last; int due; } div_t;

   logic             clk   = 1'b0;
   logic             reset = 1'b1;
   logic             clear = 1'b0;
   logic             flush = 1'b0;

   logic [4*W-1:0]   s_tdata;
   logic [1:0]       s_tlast;
   logic [1:0]       s_tvalid;
   logic [1:0]       s_tready;
   logic [2*W-1:0]   m_div_tdata;
   logic             m_div_tlast;
   logic             m_div_tvalid;
   logic             div_rdy = 1'b1;
   logic             s_div_tready;
   logic [2*W-1:0]   m_tdata;
   logic [1:0]       m_tlast;
   logic [1:0]       m_tvalid;
   logic [1:0]       mt_rdy = 2'b11;
   logic             protocol_err;

   logic [2*W-1:0]   d0 = '0, d1 = '0;
   logic             l0 = 1'b0, l1 = 1'b0, v0 = 1'b0, v1 = 1'b0;
   logic [W-1:0]     sdd = '0;
   logic             sdl = 1'b0, sdv = 1'b0;

   assign s_tdata  = {d1, d0};
   assign s_tlast  = {l1, l0};
   assign s_tvalid = {v1, v0};

   logic [2*W:0]     b0_q[$];
   logic [2*W:0]     b1_q[$];
   acc_t             acc_q[$];
   mdiv_t            mdiv_q[$];
   res_t             res_q[$];
   div_t             div_q[$];

   int               cycle = 0;
   int               pops = 0;
   int               pop_cyc = 0;
   int               mv1_seen = 0;
   int               credit_limit = 1 << 30;
   int               tests = 0;
   int               failed = 0;

   div_share_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .s_tdata      (s_tdata),
      .s_tlast      (s_tlast),
      .s_tvalid     (s_tvalid),
      .s_tready     (s_tready),
      .m_div_tdata  (m_div_tdata),
      .m_div_tlast  (m_div_tlast),
      .m_div_tvalid (m_div_tvalid),
      .m_div_tready (div_rdy),
      .s_div_tdata  (sdd),
      .s_div_tlast  (sdl),
      .s_div_tvalid (sdv),
      .s_div_tready (s_div_tready),
      .m_tdata      (m_tdata),
      .m_tlast      (m_tlast),
      .m_tvalid     (m_tvalid),
      .m_tready     (mt_rdy),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   // Handshake monitor and divider bookkeeping, sampled at the active edge.
   always @(posedge clk) begin
      if (flush) begin
         div_q.delete();
      end else if (!reset) begin
         for (int k = 0; k < 2; k++)
            if (s_tvalid[k] && s_tready[k]) acc_q.push_back('{k, cycle});
         if (m_div_tvalid && div_rdy) begin
            mdiv_q.push_back('{m_div_tdata, m_div_tlast, cycle});
            div_q.push_back('{(m_div_tdata[W-1:0] == '0) ? W'(32'hdead) :
                              m_div_tdata[2*W-1:W] / m_div_tdata[W-1:0],
                              m_div_tlast, cycle + 4});
         end
         if (sdv && s_div_tready) begin
            void'(div_q.pop_front());
            pops    = pops + 1;
            pop_cyc = cycle;
         end
         for (int k = 0; k < 2; k++)
            if (m_tvalid[k] && mt_rdy[k]) res_q.push_back('{k, m_tdata[k*W +: W], m_tlast[k]});
         if (m_tvalid[1]) mv1_seen = mv1_seen + 1;
      end
      cycle = cycle + 1;
   end

   // Divider result presentation, updated away from the active edge.
   always @(negedge clk) begin
      if (!flush && div_q.size() > 0 && pops < credit_limit && div_q[0].due <= cycle) begin
         sdv = 1'b1;
         sdd = div_q[0].q;
         sdl = div_q[0].last;
      end else begin
         sdv = 1'b0;
         sdd = '0;
         sdl = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests = tests + 1;
      if (got !== exp) begin
         failed = failed + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*W:0] beat(input int dividend, input int divisor, input bit last);
      return {last, W'(dividend), W'(divisor)};
   endfunction

   // Drives both requesters from their beat queues; called and returns at a negedge.
   task automatic run_streams(input int max_cyc, output bit done);
      logic [1:0] rdy;
      int n;
      n    = 0;
      done = 1'b0;
      forever begin
         v0 = (b0_q.size() > 0);
         v1 = (b1_q.size() > 0);
         if (v0) {l0, d0} = b0_q[0];
         if (v1) {l1, d1} = b1_q[0];
         if (!v0 && !v1) begin
            done = 1'b1;
            return;
         end
         if (n >= max_cyc) return;
         #1;
         rdy = s_tready;
         @(posedge clk);
         if (v0 && rdy[0]) void'(b0_q.pop_front());
         if (v1 && rdy[1]) void'(b1_q.pop_front());
         @(negedge clk);
         n++;
      end
   endtask

   // Waits for a presented divider result; returns at negedge+1 on success.
   task automatic wait_sdv(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         #1;
         if (sdv) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_clear();
      b0_q.delete();
      b1_q.delete();
      v0    = 1'b0;
      v1    = 1'b0;
      clear = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      flush = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int a0, m0, r0;
      bit done, ok;
      int exp_div[6]  = '{100, 101, 200, 201, 102, 103};
      int exp_k[6]    = '{0, 0, 1, 1, 0, 0};
      int exp_gap[5]  = '{1, 2, 1, 2, 1};
      int t1_q[3]     = '{5, 3, 2};
      int t1_dd[3]    = '{10, 9, 8};
      int t1_ds[3]    = '{2, 3, 4};

      // Reset values.
      repeat (2) @(negedge clk);
      #1;
      check("rst_mdiv_valid", m_div_tvalid, 0);
      check("rst_mdiv_data", m_div_tdata, 0);
      check("rst_mdiv_last", m_div_tlast, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_sdiv_tready", s_div_tready, 0);
      check("rst_protocol_err", protocol_err, 0);
      @(negedge clk);
      reset = 1'b0;

      // Single requester, three-beat packet.
      a0 = acc_q.size(); m0 = mdiv_q.size(); r0 = res_q.size();
      b0_q.push_back(beat(10, 2, 0));
      b0_q.push_back(beat(9, 3, 0));
      b0_q.push_back(beat(8, 4, 1));
      run_streams(20, done);
      check("t1_done", done, 1);
      repeat (12) @(negedge clk);
      check("t1_acc_count", acc_q.size() - a0, 3);
      check("t1_mdiv_count", mdiv_q.size() - m0, 3);
      for (int i = 0; i < 3; i++) begin
         check("t1_mdiv_data", mdiv_q[m0+i].data, {W'(t1_dd[i]), W'(t1_ds[i])});
         check("t1_mdiv_last", mdiv_q[m0+i].last, (i == 2) ? 1 : 0);
         check("t1_mdiv_latency", mdiv_q[m0+i].cyc - acc_q[a0+i].cyc, 1);
      end
      check("t1_res_count", res_q.size() - r0, 3);
      for (int i = 0; i < 3; i++) begin
         check("t1_res_k", res_q[r0+i].k, 0);
         check("t1_res_q", res_q[r0+i].data, t1_q[i]);
         check("t1_res_last", res_q[r0+i].last, (i == 2) ? 1 : 0);
      end
      check("t1_m_tvalid1_never", mv1_seen, 0);

      // Contention: R0 holds two packets, R1 one, all valid together.
      do_clear();
      a0 = acc_q.size(); m0 = mdiv_q.size(); r0 = res_q.size();
      b0_q.push_back(beat(100, 1, 0));
      b0_q.push_back(beat(101, 1, 1));
      b0_q.push_back(beat(102, 1, 0));
      b0_q.push_back(beat(103, 1, 1));
      b1_q.push_back(beat(200, 1, 0));
      b1_q.push_back(beat(201, 1, 1));
      run_streams(40, done);
      check("rr_done", done, 1);
      repeat (12) @(negedge clk);
      check("rr_mdiv_count", mdiv_q.size() - m0, 6);
      for (int i = 0; i < 6; i++) begin
         check("rr_order", mdiv_q[m0+i].data[2*W-1:W], exp_div[i]);
         check("rr_res_k", res_q[r0+i].k, exp_k[i]);
         check("rr_res_q", res_q[r0+i].data, exp_div[i]);
      end
      for (int i = 0; i < 5; i++)
         check("rr_gap", mdiv_q[m0+i+1].cyc - mdiv_q[m0+i].cyc, exp_gap[i]);

      // Zero divisor from requester 1.
      do_clear();
      m0 = mdiv_q.size(); r0 = res_q.size();
      b1_q.push_back(beat(7, 0, 1));
      run_streams(10, done);
      check("zd_done", done, 1);
      repeat (10) @(negedge clk);
      check("zd_mdiv_data", mdiv_q[m0].data, {W'(7), W'(1)});
      check("zd_res_count", res_q.size() - r0, 1);
      check("zd_res_k", res_q[r0].k, 1);
      check("zd_res_q", res_q[r0].data, 7);
      check("zd_res_last", res_q[r0].last, 1);

      // Outstanding cap with results withheld.
      do_clear();
      credit_limit = pops;
      a0 = acc_q.size();
      for (int i = 0; i < 6; i++) b0_q.push_back(beat(i + 1, 1, i == 5));
      run_streams(15, done);
      check("cap_stalled", done, 0);
      check("cap_acc_count", acc_q.size() - a0, 4);
      #1;
      check("cap_s_tready_low", s_tready, 0);
      @(negedge clk);
      credit_limit = pops + 1;
      run_streams(10, done);
      check("cap_acc_after_release", acc_q.size() - a0, 5);
      check("cap_accept_after_pop", acc_q[a0+4].cyc - pop_cyc, 1);
      #1;
      check("cap_s_tready_low_again", s_tready, 0);
      @(negedge clk);
      do_clear();
      credit_limit = 1 << 30;

      // Result backpressure: R1 result stuck ahead of R0.
      do_clear();
      r0 = res_q.size();
      mt_rdy = 2'b01;
      b1_q.push_back(beat(50, 5, 1));
      run_streams(20, done);
      check("bp_r1_done", done, 1);
      b0_q.push_back(beat(60, 4, 1));
      run_streams(20, done);
      check("bp_r0_done", done, 1);
      wait_sdv(20, ok);
      check("bp_result_seen", ok, 1);
      for (int i = 0; i < 5; i++) begin
         check("bp_sdiv_tready", s_div_tready, 0);
         check("bp_m_tvalid", m_tvalid, 2'b10);
         @(negedge clk);
         #1;
      end
      check("bp_nothing_delivered", res_q.size() - r0, 0);
      @(negedge clk);
      mt_rdy = 2'b11;
      repeat (10) @(negedge clk);
      check("bp_res_count", res_q.size() - r0, 2);
      check("bp_first_k", res_q[r0].k, 1);
      check("bp_first_q", res_q[r0].data, 10);
      check("bp_second_k", res_q[r0+1].k, 0);
      check("bp_second_q", res_q[r0+1].data, 15);

      // Asynchronous reset while beat 2 of 3 is in the output register.
      do_clear();
      a0 = acc_q.size();
      b0_q.push_back(beat(30, 3, 0));
      b0_q.push_back(beat(20, 2, 0));
      b0_q.push_back(beat(10, 1, 1));
      run_streams(3, done);
      check("mr_acc_count", acc_q.size() - a0, 2);
      check("mr_mdiv_valid_before", m_div_tvalid, 1);
      reset = 1'b1;
      #1;
      check("mr_mdiv_valid", m_div_tvalid, 0);
      check("mr_mdiv_data", m_div_tdata, 0);
      check("mr_s_tready", s_tready, 0);
      check("mr_m_tvalid", m_tvalid, 0);
      check("mr_protocol_err_low", protocol_err, 0);
      @(negedge clk);
      b0_q.delete();
      v0 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      wait_sdv(20, ok);
      check("mr_stale_seen", ok, 1);
      check("mr_stale_sdiv_tready", s_div_tready, 0);
      check("mr_stale_m_tvalid", m_tvalid, 0);
      @(posedge clk);
      #1;
      check("mr_protocol_err_set", protocol_err, 1);
      repeat (3) @(negedge clk);
      #1;
      check("mr_protocol_err_sticky", protocol_err, 1);
      @(negedge clk);
      do_clear();
      #1;
      check("clr_protocol_err", protocol_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
